// File: rtl/display_poll_pkg.sv
// display_poll_pkg: shared constants for the polled 7-segment output port.
//   - status register bit positions
//   - digit count and the blank segment pattern
//   - active-low hex segment table, bit order {g,f,e,d,c,b,a}
package display_poll_pkg;

   localparam int STAT_FULL    = 0;
   localparam int STAT_OVERRUN = 1;
   localparam int NUM_DIGITS   = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   // Active-low one-hot digit enable for a scan index.
   function automatic logic [3:0] digit_enable(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low 7-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_7seg
   import display_poll_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/display_poll.sv
// display_poll: polled CPU output port driving a 4-digit multiplexed
// active-low 7-segment display.
//   clk, rst   : clock, synchronous active-high reset
//   a0         : register select (0 = data, 1 = status)
//   wr         : one-cycle CPU write strobe
//   data_in    : CPU write data
//   data_out   : CPU read data (combinational on a0)
//   next_key   : asynchronous "value consumed" push-button, active-high
//   seg, an    : segment pattern and digit enables, both active-low
//   full_led   : copy of the FULL status bit
// Optional feature macro DISPLAY_POLL_LEADZERO_BLANK_EN blanks leading
// zero digits (digit 0 is always shown).
module display_poll
   import display_poll_pkg::*;
#(
   parameter int REFRESH_BITS = 16,
   parameter int SYNC_STAGES  = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        a0,
   input  logic        wr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        next_key,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        full_led
);

   logic [15:0]             data_reg;
   logic                    full;
   logic                    overrun;
   logic [SYNC_STAGES-1:0]  key_sync;
   logic                    key_prev;
   logic [REFRESH_BITS-1:0] prescaler;
   logic [1:0]              digit_idx;

   logic       wr_data, wr_stat, key_release;
   logic [3:0] cur_nib;
   logic [6:0] dec_seg, next_seg;
   logic       blank;

   assign wr_data = wr & ~a0;
   assign wr_stat = wr &  a0;

   // History is {key_prev, last sync stage}; 2'b10 marks the release.
   assign key_release = key_prev & ~key_sync[SYNC_STAGES-1];

   assign cur_nib = data_reg[4*digit_idx +: 4];

   hex_to_7seg u_hex (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

`ifdef DISPLAY_POLL_LEADZERO_BLANK_EN
   // Blank digit k (k>0) when it and every more significant nibble are zero.
   always_comb begin
      blank = 1'b0;
      for (int k = 1; k < NUM_DIGITS; k++)
         if (digit_idx == 2'(k) && (data_reg >> (4*k)) == 16'd0)
            blank = 1'b1;
   end
`else
   assign blank = 1'b0;
`endif

   assign next_seg = blank ? SEG_BLANK : dec_seg;

   always_comb begin
      data_out = data_reg;
      if (a0) begin
         data_out               = 16'd0;
         data_out[STAT_FULL]    = full;
         data_out[STAT_OVERRUN] = overrun;
      end
   end

   assign full_led = full;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg  <= '0;
         full      <= 1'b0;
         overrun   <= 1'b0;
         key_sync  <= '0;
         key_prev  <= 1'b0;
         prescaler <= '0;
         digit_idx <= '0;
         seg       <= SEG_LUT[0];
         an        <= 4'b1110;
      end else begin
         key_sync <= {key_sync[SYNC_STAGES-2:0], next_key};
         key_prev <= key_sync[SYNC_STAGES-1];

         prescaler <= prescaler + 1'b1;
         if (&prescaler)
            digit_idx <= digit_idx + 2'd1;

         // seg and an load together from the same index: no ghosting skew.
         an  <= digit_enable(digit_idx);
         seg <= next_seg;

         // Write is judged against pre-edge full; release clears full even
         // if a write arrives on the same edge (that write is an overrun).
         if (wr_data) begin
            if (full)
               overrun <= 1'b1;
            else
               data_reg <= data_in;
         end else if (wr_stat && data_in[STAT_OVERRUN]) begin
            overrun <= 1'b0;
         end

         if (key_release && full)
            full <= 1'b0;
         else if (wr_data && !full)
            full <= 1'b1;
      end
   end

endmodule

// File: tb/tb_display_poll.sv
// tb_display_poll: randomized scoreboard bench for display_poll.
module tb_display_poll;

   localparam int RB = 2;
   localparam int SS = 2;
`ifdef DISPLAY_POLL_LEADZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a0 = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] data_in = '0;
   logic        next_key = 1'b0;
   logic [15:0] data_out;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        full_led;

   always #5 clk = ~clk;

   display_poll #(.REFRESH_BITS(RB), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .a0(a0), .wr(wr), .data_in(data_in),
      .data_out(data_out), .next_key(next_key), .seg(seg), .an(an),
      .full_led(full_led)
   );

   // Reference segment patterns {g,f,e,d,c,b,a}, active-low.
   logic [6:0] segt [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model of the CPU-visible state.
   logic [15:0] m_data = '0;
   logic        m_full = 1'b0;
   logic        m_ovr  = 1'b0;
   time         m_chg_t = 0;
   int          cyc = 0;

   typedef struct { logic sel; logic [15:0] dout; logic led; } rd_exp_t;
   rd_exp_t sb[$];
   logic    rd_vld = 1'b0;

   function automatic logic [15:0] m_status();
      return {14'b0, m_ovr, m_full};
   endfunction

   function automatic logic [6:0] exp_seg(int k);
      logic [15:0] v;
      v = m_data >> (4*k);
      if (LZB && k > 0 && v == 16'd0) return 7'b1111111;
      return segt[v[3:0]];
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Clean cycles since reset; the digit shown is one slot per 2^RB cycles.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Monitor: checks the scan every cycle and pops reads from the scoreboard.
   always @(negedge clk) begin
      int         k;
      logic [3:0] ea;
      rd_exp_t    e;
      k  = (cyc == 0) ? 0 : ((cyc - 1) >> RB) % 4;
      ea = 4'b1111;
      ea[k] = 1'b0;
      check("an", an, ea);
      if ($time - m_chg_t > 10) check("seg", seg, exp_seg(k));
      if (rd_vld) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard: read with no expectation");
         end else begin
            e = sb.pop_front();
            check(e.sel ? "status" : "data", data_out, e.dout);
            check("full_led", full_led, e.led);
         end
      end
   end

   task automatic rd(input logic sel, input logic [15:0] exp, input logic led);
      @(posedge clk); #1;
      a0 = sel; rd_vld = 1'b1;
      sb.push_back('{sel, exp, led});
      @(negedge clk); #1;
      rd_vld = 1'b0;
   endtask

   task automatic rd_model();
      rd(1'b1, m_status(), m_full);
      rd(1'b0, m_data, m_full);
   endtask

   // One-cycle write; rel marks a key release landing on the same edge.
   task automatic write(input logic sel, input logic [15:0] d, input logic rel);
      logic old_full;
      @(posedge clk); #1;
      a0 = sel; wr = 1'b1; data_in = d;
      @(posedge clk);
      old_full = m_full;
      if (!sel) begin
         if (old_full) m_ovr = 1'b1;
         else begin m_data = d; m_full = 1'b1; m_chg_t = $time; end
      end else if (d[1]) m_ovr = 1'b0;
      if (rel && old_full) m_full = 1'b0;
      #1 wr = 1'b0;
   endtask

   task automatic press();
      @(posedge clk); #1 next_key = 1'b1;
      repeat (10) @(posedge clk);
      #1 next_key = 1'b0;
   endtask

   // Press/release; FULL must drop exactly SS+1 edges after the fall.
   task automatic key_cycle();
      logic old;
      press();
      old = m_full;
      for (int i = 1; i <= SS + 1; i++) begin
         logic f;
         f = (i == SS + 1) ? 1'b0 : old;
         rd(1'b1, {14'b0, m_ovr, f}, f);
      end
      m_full = 1'b0;
   endtask

   // Release and data write hit the same edge.
   task automatic key_collide(input logic [15:0] d);
      press();
      @(posedge clk);
      write(1'b0, d, 1'b1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      m_data = '0; m_full = 1'b0; m_ovr = 1'b0; m_chg_t = $time;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rd(1'b1, 16'h0000, 1'b0);

      write(1'b0, 16'h12AF, 1'b0);
      rd(1'b1, 16'h0001, 1'b1);
      rd(1'b0, 16'h12AF, 1'b1);
      repeat (20) @(posedge clk);

      write(1'b0, 16'h5555, 1'b0);
      rd(1'b0, 16'h12AF, 1'b1);
      rd(1'b1, 16'h0003, 1'b1);
      write(1'b1, 16'h0002, 1'b0);
      rd(1'b1, 16'h0001, 1'b1);

      key_cycle();
      key_cycle();
      rd(1'b1, 16'h0000, 1'b0);
      rd(1'b0, 16'h12AF, 1'b0);
      repeat (20) @(posedge clk);

      write(1'b0, 16'h12AF, 1'b0);
      key_collide(16'h0BAD);
      rd(1'b1, 16'h0002, 1'b0);
      rd(1'b0, 16'h12AF, 1'b0);
      write(1'b0, 16'h0BAD, 1'b0);
      rd(1'b1, 16'h0003, 1'b1);
      rd(1'b0, 16'h0BAD, 1'b1);

      write(1'b1, 16'h0002, 1'b0);
      key_cycle();
      write(1'b0, 16'h00A5, 1'b0);
      repeat (20) @(posedge clk);
      key_cycle();
      write(1'b0, 16'h0000, 1'b0);
      repeat (20) @(posedge clk);

      // Reset mid-scan with FULL set.
      repeat (3) @(posedge clk);
      do_reset();
      rd(1'b1, 16'h0000, 1'b0);
      rd(1'b0, 16'h0000, 1'b0);

      for (int n = 0; n < 200; n++) begin
         int          op;
         logic [15:0] d;
         op = $urandom_range(0, 9);
         d  = 16'($urandom);
         if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 4));
         case (op)
            0, 1, 2, 3: write(1'b0, d, 1'b0);
            4:          write(1'b1, d, 1'b0);
            5, 6:       rd_model();
            7:          key_cycle();
            8:          repeat ($urandom_range(1, 12)) @(posedge clk);
            default:    if ($urandom_range(0, 7) == 0) do_reset();
                        else repeat (4) @(posedge clk);
         endcase
      end
      rd_model();
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
